// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_0    = 2'd1,
    GNT_1    = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register reserved by the
// long-latency unit, with conflict detection and source hazard lookup.
module rf_scoreboard #(
  parameter int ADDR_W = rf_write_arbiter_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic                    clr_valid,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic [ADDR_W-1:0]       rs2_addr,
  output logic [(1<<ADDR_W)-1:0]  pending,
  output logic                    hazard,
  output logic                    rsv_conflict
);
  import rf_write_arbiter_pkg::*;

  logic [(1<<ADDR_W)-1:0] set_vec;
  logic [(1<<ADDR_W)-1:0] clr_vec;
  logic [(1<<ADDR_W)-1:0] pend_p1;
  logic                   conf_p1;
  logic                   rsv_hit;

  // Build one-hot set/clear masks; x0 is never reserved.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid && (rsv_addr != ADDR_W'(ZERO_REG))) set_vec[rsv_addr] = 1'b1;
    if (clr_valid) clr_vec[clr_addr] = 1'b1;
  end

  assign rsv_hit = rsv_valid && pend_p1[rsv_addr];

  // Bitmap update: clear first, then set, so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p1 <= '0;
      conf_p1 <= 1'b0;
    end else begin
      pend_p1 <= (pend_p1 & ~clr_vec) | set_vec;
      conf_p1 <= rsv_hit;
    end
  end

  assign pending      = pend_p1;
  assign rsv_conflict = conf_p1;
  assign hazard       = pend_p1[rs1_addr] | pend_p1[rs2_addr];

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register file write port, with
// starvation protection for the long-latency requester and a
// registered write stage driving we/a3/wd3.
module rf_write_arbiter #(
  parameter int ADDR_W   = rf_write_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = rf_write_arbiter_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic [ADDR_W-1:0]       rs2_addr,
  output logic                    hazard,
  output logic [(1<<ADDR_W)-1:0]  pending,
  output logic                    rsv_conflict,
  output logic                    we,
  output logic [ADDR_W-1:0]       a3,
  output logic [DATA_W-1:0]       wd3
);
  import rf_write_arbiter_pkg::*;

  gnt_e              gnt;
  logic [3:0]        starve_cnt;
  logic              xfer;
  logic              xfer1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_p1;
  logic [ADDR_W-1:0] a3_p1;
  logic [DATA_W-1:0] wd3_p1;

  // Denial counter increment, saturating at the forced-grant threshold.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= 4'(MAX_WAIT)) return 4'(MAX_WAIT);
    return cnt + 4'd1;
  endfunction

  // Grant priority: starved requester 1, then core writeback, then requester 1.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n)                                        gnt = GNT_NONE;
    else if (req1_valid && (starve_cnt == 4'(MAX_WAIT))) gnt = GNT_1;
    else if (req0_valid)                               gnt = GNT_0;
    else if (req1_valid)                               gnt = GNT_1;
  end

  assign req0_ready = (gnt == GNT_0);
  assign req1_ready = (gnt == GNT_1);
  assign xfer       = (gnt != GNT_NONE);
  assign xfer1      = (gnt == GNT_1);

  // Route the granted requester onto the write stage inputs.
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (gnt == GNT_1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
  end

  // Count consecutive denials of requester 1; any idle or granted cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!req1_valid || xfer1) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Write stage: capture the transfer; x0 writes are accepted but not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1  <= 1'b0;
      a3_p1  <= '0;
      wd3_p1 <= '0;
    end else if (xfer) begin
      we_p1  <= (sel_addr != ADDR_W'(ZERO_REG));
      a3_p1  <= sel_addr;
      wd3_p1 <= sel_data;
    end else begin
      we_p1  <= 1'b0;
    end
  end

  assign we  = we_p1;
  assign a3  = a3_p1;
  assign wd3 = wd3_p1;

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .clr_valid    (xfer1),
    .clr_addr     (req1_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .pending      (pending),
    .hazard       (hazard),
    .rsv_conflict (rsv_conflict)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written corner
// sequences, then constrained-random traffic against a behavioural model.
module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, rsv_valid;
  logic [AW-1:0] req0_addr, req1_addr, rsv_addr, rs1_addr, rs2_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, hazard, rsv_conflict, we;
  logic [NR-1:0] pending;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard(hazard), .pending(pending), .rsv_conflict(rsv_conflict),
    .we(we), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rsv_valid  = 1'b0; rsv_addr  = '0;
    rs1_addr   = '0;   rs2_addr  = '0;
  endtask

  typedef struct {
    logic          r0v;
    logic [AW-1:0] r0a;
    logic          r1v;
    logic [AW-1:0] r1a;
    logic          rsv;
    logic [AW-1:0] rsva;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          e_rdy0;
    logic          e_rdy1;
    logic          e_haz;
    logic          e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd3;
    logic [NR-1:0] e_pend;
    logic          e_conf;
  } vec_t;

  localparam logic [DW-1:0] D0 = 32'h1000_0000;
  localparam logic [DW-1:0] D1 = 32'h2000_0000;
  localparam logic [NR-1:0] P7 = 32'h0000_0080;
  localparam logic [NR-1:0] P9 = 32'h0000_0200;

  vec_t tbl[10];

  // Behavioural reference state for the random phase
  logic [NR-1:0] m_pend;
  logic          m_conf, m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  int            m_deny;

  initial begin
    tbl[0] = '{0,0, 0,0, 1,7, 7,0,  0,0,0, 0,0, 32'h0,   P7,   0};
    tbl[1] = '{1,5, 0,0, 0,0, 7,0,  1,0,1, 1,5, D0+1,    P7,   0};
    tbl[2] = '{1,0, 0,0, 0,0, 0,0,  1,0,0, 0,0, D0+2,    P7,   0};
    tbl[3] = '{0,0, 0,0, 1,0, 0,7,  0,0,1, 0,0, D0+2,    P7,   0};
    tbl[4] = '{0,0, 1,7, 0,0, 7,0,  0,1,1, 1,7, D1+4,    32'h0,0};
    tbl[5] = '{0,0, 0,0, 1,9, 7,0,  0,0,0, 0,7, D1+4,    P9,   0};
    tbl[6] = '{0,0, 1,9, 1,9, 9,0,  0,1,1, 1,9, D1+6,    P9,   1};
    tbl[7] = '{0,0, 0,0, 0,0, 9,0,  0,0,1, 0,9, D1+6,    P9,   0};
    tbl[8] = '{1,3, 1,9, 0,0, 0,0,  1,0,0, 1,3, D0+8,    P9,   0};
    tbl[9] = '{0,0, 1,9, 0,0, 9,0,  0,1,1, 1,9, D1+9,    32'h0,0};

    // Reset state, with a request present to show grants are held off
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req1_valid = 1'b1;
    tick(); tick();
    chk("reset we",    64'(we), 64'(0));
    chk("reset a3",    64'(a3), 64'(0));
    chk("reset wd3",   64'(wd3), 64'(0));
    chk("reset pend",  64'(pending), 64'(0));
    chk("reset conf",  64'(rsv_conflict), 64'(0));
    chk("reset rdy0",  64'(req0_ready), 64'(0));
    chk("reset rdy1",  64'(req1_ready), 64'(0));
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].r0v; req0_addr = tbl[i].r0a; req0_data = D0 + DW'(i);
      req1_valid = tbl[i].r1v; req1_addr = tbl[i].r1a; req1_data = D1 + DW'(i);
      rsv_valid  = tbl[i].rsv; rsv_addr  = tbl[i].rsva;
      rs1_addr   = tbl[i].rs1; rs2_addr  = tbl[i].rs2;
      #3;
      chk($sformatf("vec%0d rdy0", i), 64'(req0_ready), 64'(tbl[i].e_rdy0));
      chk($sformatf("vec%0d rdy1", i), 64'(req1_ready), 64'(tbl[i].e_rdy1));
      chk($sformatf("vec%0d haz", i),  64'(hazard),     64'(tbl[i].e_haz));
      tick();
      chk($sformatf("vec%0d we", i),   64'(we),           64'(tbl[i].e_we));
      chk($sformatf("vec%0d a3", i),   64'(a3),           64'(tbl[i].e_a3));
      chk($sformatf("vec%0d wd3", i),  64'(wd3),          64'(tbl[i].e_wd3));
      chk($sformatf("vec%0d pend", i), 64'(pending),      64'(tbl[i].e_pend));
      chk($sformatf("vec%0d conf", i), 64'(rsv_conflict), 64'(tbl[i].e_conf));
    end
    idle_inputs();

    // Contention: requester 1 forced in on every fifth cycle
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hAAAA_0012;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBBBB_0011;
    for (int k = 0; k < 10; k++) begin
      #3;
      chk($sformatf("cont%0d rdy0", k), 64'(req0_ready), 64'((k % 5) != 4));
      chk($sformatf("cont%0d rdy1", k), 64'(req1_ready), 64'((k % 5) == 4));
      tick();
      chk($sformatf("cont%0d a3", k), 64'(a3), 64'(((k % 5) == 4) ? 11 : 12));
      chk($sformatf("cont%0d we", k), 64'(we), 64'(1));
    end

    // Reset mid-operation
    rsv_valid = 1'b1; rsv_addr = 5'd13;
    tick();
    rsv_valid = 1'b0;
    chk("pre-reset pend", 64'(pending), 64'(32'h0000_2000));
    #2 rst_n = 1'b0;
    #1;
    chk("async we",   64'(we), 64'(0));
    chk("async a3",   64'(a3), 64'(0));
    chk("async wd3",  64'(wd3), 64'(0));
    chk("async pend", 64'(pending), 64'(0));
    chk("async conf", 64'(rsv_conflict), 64'(0));
    chk("async rdy0", 64'(req0_ready), 64'(0));
    req1_valid = 1'b0;
    req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("post-reset we",  64'(we), 64'(1));
    chk("post-reset a3",  64'(a3), 64'(5));
    chk("post-reset wd3", 64'(wd3), 64'(32'hDEAD_BEEF));

    // Idle: outputs hold, write enable stays low
    req0_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle%0d we", k),  64'(we),  64'(0));
      chk($sformatf("idle%0d a3", k),  64'(a3),  64'(5));
      chk($sformatf("idle%0d wd3", k), 64'(wd3), 64'(32'hDEAD_BEEF));
    end

    // Counter restarted during idle: requester 0 again wins MAX_WAIT cycles
    req0_valid = 1'b1; req0_addr = 5'd12;
    req1_valid = 1'b1; req1_addr = 5'd11;
    for (int k = 0; k <= MW; k++) begin
      #3;
      chk($sformatf("after-idle%0d rdy1", k), 64'(req1_ready), 64'(k == MW));
      tick();
    end
    idle_inputs();

    // Random traffic against the behavioural model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_pend = '0; m_conf = 1'b0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_deny = 0;
    begin
      bit h0 = 0;
      bit h1 = 0;
      int g;
      for (int c = 0; c < 500; c++) begin
        if (!h0) begin
          req0_valid = ($urandom_range(0, 99) < 60);
          req0_addr  = AW'($urandom_range(0, 7));
          req0_data  = $urandom;
        end
        if (!h1) begin
          req1_valid = ($urandom_range(0, 99) < 50);
          req1_addr  = AW'($urandom_range(0, 7));
          req1_data  = $urandom;
        end
        rsv_valid = ($urandom_range(0, 99) < 30);
        rsv_addr  = AW'($urandom_range(0, 7));
        rs1_addr  = AW'($urandom_range(0, 7));
        rs2_addr  = AW'($urandom_range(0, 7));
        #3;
        if (req1_valid && m_deny == MW) g = 1;
        else if (req0_valid)            g = 0;
        else if (req1_valid)            g = 1;
        else                            g = -1;
        chk($sformatf("rnd%0d rdy0", c), 64'(req0_ready), 64'(g == 0));
        chk($sformatf("rnd%0d rdy1", c), 64'(req1_ready), 64'(g == 1));
        chk($sformatf("rnd%0d haz", c), 64'(hazard),
            64'(m_pend[rs1_addr] | m_pend[rs2_addr]));
        @(posedge clk);
        m_conf = rsv_valid && m_pend[rsv_addr];
        if (g == 1) m_pend[req1_addr] = 1'b0;
        if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        if (g == 0) begin
          m_we = (req0_addr != 0); m_a3 = req0_addr; m_wd3 = req0_data;
        end else if (g == 1) begin
          m_we = (req1_addr != 0); m_a3 = req1_addr; m_wd3 = req1_data;
        end else begin
          m_we = 1'b0;
        end
        if (req1_valid && g != 1) m_deny = (m_deny < MW) ? m_deny + 1 : MW;
        else                      m_deny = 0;
        h0 = req0_valid && (g != 0);
        h1 = req1_valid && (g != 1);
        #1;
        chk($sformatf("rnd%0d we", c),   64'(we),           64'(m_we));
        chk($sformatf("rnd%0d a3", c),   64'(a3),           64'(m_a3));
        chk($sformatf("rnd%0d wd3", c),  64'(wd3),          64'(m_wd3));
        chk($sformatf("rnd%0d pend", c), 64'(pending),      64'(m_pend));
        chk($sformatf("rnd%0d conf", c), 64'(rsv_conflict), 64'(m_conf));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
